// File: rtl/rf_wb_clear_queue.sv
// rtl/rf_wb_clear_queue.sv - writeback response queue draining into idle RF write slots
// Issues a scoreboard clear alongside each write and requests a stall when the head starves.
module rf_wb_clear_queue #(
  parameter int els_p             = 32,
  parameter int data_width_p      = 32,
  parameter int depth_p           = 4,
  parameter int starve_limit_p    = 16,
  parameter int x0_tied_to_zero_p = 1,
  parameter int id_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int count_width_lp    = $clog2(depth_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      resp_v_i,
  input  logic [id_width_lp-1:0]    resp_id_i,
  input  logic [data_width_p-1:0]   resp_data_i,
  output logic                      resp_ready_o,
  input  logic                      wb_slot_free_i,
  output logic                      rf_wen_o,
  output logic [id_width_lp-1:0]    rf_waddr_o,
  output logic [data_width_p-1:0]   rf_wdata_o,
  output logic                      clear_o,
  output logic [id_width_lp-1:0]    clear_id_o,
  output logic                      stall_req_o,
  output logic [count_width_lp-1:0] count_o
);

  localparam int ptr_width_lp    = $clog2(depth_p);
  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [count_width_lp-1:0]  full_count_lp  = count_width_lp'(depth_p);
  localparam logic [starve_width_lp-1:0] starve_max_lp  = starve_width_lp'(starve_limit_p);

  logic [id_width_lp-1:0]     id_mem   [depth_p];
  logic [data_width_p-1:0]    data_mem [depth_p];
  logic [ptr_width_lp-1:0]    head_q, tail_q;
  logic [count_width_lp-1:0]  count_q;
  logic [starve_width_lp-1:0] starve_q, starve_d;
  logic                       stall_q;

  logic empty, full, push, discard, bypass, enq, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == full_count_lp);
  assign push    = resp_v_i & ~full;
  assign discard = (x0_tied_to_zero_p != 0) && (resp_id_i == '0);
  assign pop     = wb_slot_free_i & ~empty;
  // An empty queue with a free slot forwards the response straight to the RF.
  assign bypass  = push & ~discard & empty & wb_slot_free_i;
  assign enq     = push & ~discard & ~bypass;

  // Outputs are forced quiet while reset is held so a mid-operation reset drops entries silently.
  assign resp_ready_o = ~reset_n_i | ~full;
  assign rf_wen_o     = reset_n_i & (pop | bypass);
  assign clear_o      = rf_wen_o;
  assign rf_waddr_o   = pop ? id_mem[head_q] : resp_id_i;
  assign rf_wdata_o   = pop ? data_mem[head_q] : resp_data_i;
  assign clear_id_o   = rf_waddr_o;
  assign stall_req_o  = reset_n_i & stall_q;
  assign count_o      = reset_n_i ? count_q : '0;

  always_comb begin
    starve_d = '0;
    if (!pop && !empty) begin
      starve_d = (starve_q == starve_max_lp) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      id_mem[tail_q]   <= resp_id_i;
      data_mem[tail_q] <= resp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      starve_q <= starve_d;
      stall_q  <= (starve_d == starve_max_lp);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(enq && full)) else $error("enqueue while full");
      assert (!clear_o || rf_wen_o) else $error("clear without write");
      assert (count_q <= full_count_lp) else $error("count overflow");
      assert (!(x0_tied_to_zero_p != 0 && clear_o && clear_id_o == '0))
        else $error("clear of register 0");
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_clear_queue.sv
// tb/tb_rf_wb_clear_queue.sv - directed self-checking bench for rf_wb_clear_queue
module tb_rf_wb_clear_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        resp_v;
  logic [4:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        wb_slot_free;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        clear;
  logic [4:0]  clear_id;
  logic        stall_req;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_clear_queue dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .resp_v_i(resp_v), .resp_id_i(resp_id), .resp_data_i(resp_data),
    .resp_ready_o(resp_ready), .wb_slot_free_i(wb_slot_free),
    .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .clear_o(clear), .clear_id_o(clear_id),
    .stall_req_o(stall_req), .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_chk(input string tag, input logic [4:0] id, input logic [31:0] data);
    chk({tag, "_wen"}, 64'(rf_wen), 64'd1);
    chk({tag, "_clear"}, 64'(clear), 64'd1);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(id));
    chk({tag, "_clear_id"}, 64'(clear_id), 64'(id));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(data));
  endtask

  initial begin
    reset_n = 1'b0; resp_v = 1'b0; resp_id = '0; resp_data = '0; wb_slot_free = 1'b0;

    // Reset state
    step();
    #1;
    chk("rst_ready", 64'(resp_ready), 64'd1);
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_clear", 64'(clear), 64'd0);

    // 1: bypass
    resp_v = 1'b1; resp_id = 5'd5; resp_data = 32'hDEADBEEF; wb_slot_free = 1'b1;
    #1;
    write_chk("bypass", 5'd5, 32'hDEADBEEF);
    chk("bypass_count", 64'(count), 64'd0);
    step();
    resp_v = 1'b0;
    #1;
    chk("bypass_count_after", 64'(count), 64'd0);

    // 2: fill and order
    wb_slot_free = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      resp_v = 1'b1; resp_id = 5'(i); resp_data = 32'(8'h11 * i);
      #1;
      chk("fill_ready", 64'(resp_ready), 64'd1);
      chk("fill_no_wen", 64'(rf_wen), 64'd0);
      step();
    end
    resp_id = 5'd6; resp_data = 32'h66;
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(resp_ready), 64'd0);
    step();
    chk("held_count", 64'(count), 64'd4);
    wb_slot_free = 1'b1;
    #1;
    write_chk("pop1", 5'd1, 32'h11);
    chk("pop1_ready", 64'(resp_ready), 64'd0);
    step();
    resp_v = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      #1;
      write_chk("popk", 5'(k), 32'(8'h11 * k));
      chk("popk_ready", 64'(resp_ready), 64'd1);
      step();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_wen", 64'(rf_wen), 64'd0);

    // 3: x0 discard
    resp_v = 1'b1; resp_id = 5'd0; resp_data = 32'h99; wb_slot_free = 1'b1;
    #1;
    chk("x0_wen", 64'(rf_wen), 64'd0);
    chk("x0_clear", 64'(clear), 64'd0);
    chk("x0_ready", 64'(resp_ready), 64'd1);
    step();
    resp_v = 1'b0;
    #1;
    chk("x0_count", 64'(count), 64'd0);

    // 4: starvation
    resp_v = 1'b1; resp_id = 5'd7; resp_data = 32'h77; wb_slot_free = 1'b0;
    #1;
    chk("starve_enq_wen", 64'(rf_wen), 64'd0);
    step();
    resp_v = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk("starve_low", 64'(stall_req), 64'd0);
      step();
    end
    #1;
    chk("starve_high17", 64'(stall_req), 64'd1);
    chk("starve_count", 64'(count), 64'd1);
    step();
    chk("starve_high18", 64'(stall_req), 64'd1);
    wb_slot_free = 1'b1;
    #1;
    write_chk("starve_pop", 5'd7, 32'h77);
    step();
    wb_slot_free = 1'b0;
    #1;
    chk("starve_released", 64'(stall_req), 64'd0);
    chk("starve_empty", 64'(count), 64'd0);

    // 5: simultaneous push/pop across pointer wrap (head=1, tail=1 -> tail=3)
    resp_v = 1'b1; resp_id = 5'd10; resp_data = 32'hA0;
    step();
    resp_id = 5'd11; resp_data = 32'hB0;
    step();
    resp_v = 1'b0;
    #1;
    chk("wrap_pre_count", 64'(count), 64'd2);
    wb_slot_free = 1'b1; resp_v = 1'b1; resp_id = 5'd9;
    for (int i = 0; i < 6; i++) begin
      resp_data = 32'h900 + 32'(i);
      #1;
      if (i == 0)      write_chk("wrap_pop", 5'd10, 32'hA0);
      else if (i == 1) write_chk("wrap_pop", 5'd11, 32'hB0);
      else             write_chk("wrap_pop", 5'd9, 32'h900 + 32'(i - 2));
      chk("wrap_count", 64'(count), 64'd2);
      step();
    end
    chk("wrap_post_count", 64'(count), 64'd2);

    // 6: reset mid-operation
    resp_id = 5'd12; resp_data = 32'hC0; wb_slot_free = 1'b0;
    step();
    resp_v = 1'b0;
    #1;
    chk("mid_pre_count", 64'(count), 64'd3);
    reset_n = 1'b0; wb_slot_free = 1'b1;
    #1;
    chk("mid_rst_wen", 64'(rf_wen), 64'd0);
    chk("mid_rst_clear", 64'(clear), 64'd0);
    chk("mid_rst_ready", 64'(resp_ready), 64'd1);
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_after_wen", 64'(rf_wen), 64'd0);
    chk("mid_after_clear", 64'(clear), 64'd0);
    chk("mid_after_count", 64'(count), 64'd0);
    chk("mid_after_stall", 64'(stall_req), 64'd0);
    step();
    chk("mid_later_wen", 64'(rf_wen), 64'd0);
    chk("mid_later_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_clear_queue.md
Name: rf_wb_clear_queue

Overview:
- Buffers long-latency register writeback responses (remote loads, iterative divide results) returning to the vanilla core.
- Drains them into the integer register file write port whenever the main pipeline leaves that port idle.
- Drives the scoreboard clear port for the same register id in the same cycle as the write.
- A starvation counter requests a one-cycle pipeline stall when the head entry waits too long.

Parameters:
- els_p, 32, number of architectural registers.
- data_width_p, 32, writeback data width.
- depth_p, 4, queue entries; power of two, at least 2.
- starve_limit_p, 16, consecutive blocked cycles before stall_req_o asserts; at least 1.
- x0_tied_to_zero_p, 1, when 1, responses to id 0 are discarded.
- id_width_lp, BSG_SAFE_CLOG2(els_p), register id width.

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: synchronous, active-low reset.
- resp_v_i, in, 1: response valid.
- resp_id_i, in, id_width_lp: destination register id.
- resp_data_i, in, data_width_p: writeback data.
- resp_ready_o, out, 1: queue can accept a response.
- wb_slot_free_i, in, 1: the pipeline does not use the RF write port this cycle.
- rf_wen_o, out, 1: register file write enable.
- rf_waddr_o, out, id_width_lp: register file write address.
- rf_wdata_o, out, data_width_p: register file write data.
- clear_o, out, 1: scoreboard clear valid.
- clear_id_o, out, id_width_lp: scoreboard clear id; always equals rf_waddr_o.
- stall_req_o, out, 1: request to hold the pipeline so its write slot is freed next cycle.
- count_o, out, BSG_SAFE_CLOG2(depth_p+1): number of occupied entries.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - head pointer, tail pointer, count and starve counter clear to 0; stall_req_o register clears to 0.
  - Outputs during and after reset: resp_ready_o=1, rf_wen_o=0, clear_o=0, stall_req_o=0, count_o=0.
  - Entry storage is not reset.
  - Reset mid-operation drops all queued entries with no write and no clear.
- Accept:
  - push = resp_v_i & resp_ready_o.
  - resp_ready_o = (count_o != depth_p). It is registered-state based and does not look at the same-cycle pop.
  - When full, a same-cycle pop does not open a slot for a push in that cycle.
- Discard:
  - When x0_tied_to_zero_p=1 and resp_id_i==0, the response is accepted but not enqueued.
  - A discarded response produces no write and no clear.
- Drain, combinational from head state and inputs:
  - pop = wb_slot_free_i & (count_o != 0).
  - On pop: rf_wen_o=1, clear_o=1, rf_waddr_o=clear_id_o=head id, rf_wdata_o=head data. The head pointer advances at the posedge.
- Bypass:
  - Condition: count_o==0, a non-discarded push, and wb_slot_free_i=1.
  - The response is written and cleared in the same cycle and is not enqueued.
  - Zero-cycle latency.
- Latency otherwise:
  - An enqueued entry drains in the first cycle in which it is at the head and wb_slot_free_i=1.
  - Order is strict FIFO.
- Count update:
  - count_next = count + (enqueue) − (pop). A bypass changes neither.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo depth_p.
- Starvation:
  - starve counter increments each cycle with count_o!=0 and wb_slot_free_i=0; it saturates at starve_limit_p.
  - It clears to 0 on any pop or whenever count_o==0.
  - stall_req_o is registered: it is 1 in the cycle after the counter reaches starve_limit_p, and stays 1 until the pop that services the head.
  - In the cycle after that pop, stall_req_o is 0 and the counter restarts at 0 for the new head.
  - The pipeline is expected to assert wb_slot_free_i while stall_req_o=1.
- Invariants (assertions, translate_off):
  - no push when full;
  - clear_o implies rf_wen_o;
  - count_o never exceeds depth_p;
  - with x0_tied_to_zero_p=1, clear_id_o is never 0 while clear_o=1.

Test Plan:
1. Reset, then bypass:
   - Stimulus: reset_n_i low 2 cycles. Then resp_v_i=1, id=5, data=0xDEADBEEF, wb_slot_free_i=1.
   - Required: same cycle rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, clear_o=1, clear_id_o=5. count_o stays 0.
2. Fill and order:
   - Stimulus: wb_slot_free_i=0. Push ids 1, 2, 3, 4 with data 0x11, 0x22, 0x33, 0x44.
   - Required: count_o=4 and resp_ready_o=0. A 5th response (id=6) is held.
   - Then set wb_slot_free_i=1 for 4 cycles. Required: writes to ids 1, 2, 3, 4 in order with matching data, one clear per cycle. resp_ready_o=1 after the first pop.
3. x0 discard:
   - Stimulus: push id=0, data=0x99, wb_slot_free_i=1.
   - Required: rf_wen_o=0, clear_o=0, count_o=0, resp_ready_o=1.
4. Starvation:
   - Stimulus: push id=7, hold wb_slot_free_i=0.
   - Required: stall_req_o=0 for cycles 1–16 after enqueue and 1 from cycle 17.
   - Then set wb_slot_free_i=1. Required: write/clear of id 7. stall_req_o=0 the following cycle.
5. Simultaneous push/pop with wrap:
   - Stimulus: with count_o=2 and the tail pointer at 3, push id=9 while popping for 6 cycles.
   - Required: count_o stays 2, and ids emerge in FIFO order across the wrap.
6. Reset mid-operation:
   - Stimulus: with count_o=3, assert reset_n_i=0 for 1 cycle, with wb_slot_free_i=1.
   - Required: no rf_wen_o or clear_o during or after reset. count_o=0 and stall_req_o=0 after reset.
